// File: rtl/sram_req_bridge.sv
// N-channel round-robin request bridge onto one split-handshake sram-like port.
// A hold register issues the next request while an ID FIFO routes in-order responses.
module sram_req_bridge #(
   parameter int NCH   = 2,
   parameter int AW    = 32,
   parameter int DW    = 32,
   parameter int DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NCH-1:0]        ch_req,
   input  logic [NCH-1:0]        ch_wr,
   input  logic [NCH*DW/8-1:0]   ch_wstrb,
   input  logic [NCH*AW-1:0]     ch_addr,
   input  logic [NCH*DW-1:0]     ch_wdata,
   output logic [NCH-1:0]        ch_addr_ok,
   output logic [NCH-1:0]        ch_data_ok,
   output logic [DW-1:0]         ch_rdata,
   output logic                  mem_req,
   output logic                  mem_wr,
   output logic [DW/8-1:0]       mem_wstrb,
   output logic [AW-1:0]         mem_addr,
   output logic [DW-1:0]         mem_wdata,
   input  logic                  mem_addr_ok,
   input  logic                  mem_data_ok,
   input  logic [DW-1:0]         mem_rdata,
   output logic                  busy
);

   localparam int SW = DW / 8;
   localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;
   localparam int PW = $clog2(DEPTH + 1);
   localparam int FW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PW-1:0] P_DEPTH = PW'(DEPTH);
   localparam logic [FW-1:0] F_LAST  = FW'(DEPTH - 1);
   localparam logic [IW-1:0] ID_LAST = IW'(NCH - 1);

   logic            r_hold_valid;
   logic            r_hold_wr;
   logic [SW-1:0]   r_hold_wstrb;
   logic [AW-1:0]   r_hold_addr;
   logic [DW-1:0]   r_hold_wdata;
   logic [IW-1:0]   r_hold_id;
   logic [PW-1:0]   r_pend;
   logic [IW-1:0]   r_last;
   logic [IW-1:0]   r_fifo [DEPTH];
   logic [FW-1:0]   r_wptr;
   logic [FW-1:0]   r_rptr;
   logic [PW-1:0]   r_fcnt;

   logic            w_found;
   logic [IW-1:0]   w_gnt;
   logic            w_cap;
   logic            w_hand;
   logic            w_pop;
   logic [IW-1:0]   w_head;

   function automatic logic [FW-1:0] f_inc(input logic [FW-1:0] p);
      return (p == F_LAST) ? '0 : p + 1'b1;
   endfunction

   // Round-robin: scan last+1 .. last+NCH, first requester wins.
   always_comb begin
      logic [IW-1:0] c;
      w_found = 1'b0;
      w_gnt   = '0;
      c       = r_last;
      for (int k = 0; k < NCH; k++) begin
         c = (c == ID_LAST) ? '0 : c + 1'b1;
         if (!w_found && ch_req[c]) begin
            w_found = 1'b1;
            w_gnt   = c;
         end
      end
   end

   // Credit uses the registered count only; a same-cycle response frees nothing.
   assign w_cap  = !rst && w_found && (!r_hold_valid || mem_addr_ok) && (r_pend < P_DEPTH);
   assign w_hand = r_hold_valid && mem_addr_ok;
   assign w_pop  = mem_data_ok && (r_fcnt != '0);
   assign w_head = r_fifo[r_rptr];

   assign ch_addr_ok = w_cap ? (NCH'(1) << w_gnt) : '0;
   assign ch_data_ok = w_pop ? (NCH'(1) << w_head) : '0;
   assign ch_rdata   = mem_rdata;

   assign mem_req   = r_hold_valid;
   assign mem_wr    = r_hold_wr;
   assign mem_wstrb = r_hold_wstrb;
   assign mem_addr  = r_hold_addr;
   assign mem_wdata = r_hold_wdata;
   assign busy      = (r_pend != '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_hold_valid <= 1'b0;
         r_hold_wr    <= 1'b0;
         r_hold_wstrb <= '0;
         r_hold_addr  <= '0;
         r_hold_wdata <= '0;
         r_hold_id    <= '0;
         r_last       <= ID_LAST;
      end else if (w_cap) begin
         r_hold_valid <= 1'b1;
         r_hold_wr    <= ch_wr[w_gnt];
         r_hold_wstrb <= ch_wstrb[int'(w_gnt)*SW +: SW];
         r_hold_addr  <= ch_addr[int'(w_gnt)*AW +: AW];
         r_hold_wdata <= ch_wdata[int'(w_gnt)*DW +: DW];
         r_hold_id    <= w_gnt;
         r_last       <= w_gnt;
      end else if (w_hand) begin
         r_hold_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pend <= '0;
      end else begin
         r_pend <= r_pend + PW'(w_cap) - PW'(w_pop);
      end
   end

   // ID FIFO cannot overflow: the pending credit already counts hold + FIFO.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) r_fifo[i] <= '0;
         r_wptr <= '0;
         r_rptr <= '0;
         r_fcnt <= '0;
      end else begin
         if (w_hand) begin
            r_fifo[r_wptr] <= r_hold_id;
            r_wptr         <= f_inc(r_wptr);
         end
         if (w_pop) r_rptr <= f_inc(r_rptr);
         r_fcnt <= r_fcnt + PW'(w_hand) - PW'(w_pop);
      end
   end

endmodule

// File: tb/tb_sram_req_bridge.sv
// Self-checking bench: fixed vector table, directed corner sequences, then
// randomized traffic checked against a transaction-level queue model.
module tb_sram_req_bridge;
   localparam int NCH = 2, AW = 32, DW = 32, DEPTH = 4, SW = DW / 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [NCH-1:0]          ch_req, ch_wr;
   logic [NCH-1:0][SW-1:0]  ch_wstrb;
   logic [NCH-1:0][AW-1:0]  ch_addr;
   logic [NCH-1:0][DW-1:0]  ch_wdata;
   logic [NCH-1:0]          ch_addr_ok, ch_data_ok;
   logic [DW-1:0]           ch_rdata, mem_wdata, mem_rdata;
   logic                    mem_req, mem_wr, mem_addr_ok, mem_data_ok, busy;
   logic [SW-1:0]           mem_wstrb;
   logic [AW-1:0]           mem_addr;

   sram_req_bridge #(.NCH(NCH), .AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .ch_req(ch_req), .ch_wr(ch_wr), .ch_wstrb(ch_wstrb),
      .ch_addr(ch_addr), .ch_wdata(ch_wdata), .ch_addr_ok(ch_addr_ok),
      .ch_data_ok(ch_data_ok), .ch_rdata(ch_rdata), .mem_req(mem_req), .mem_wr(mem_wr),
      .mem_wstrb(mem_wstrb), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata),
      .busy(busy)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic [1:0]  req;
      logic [1:0]  wr;
      logic        aok;
      logic        dok;
      logic [31:0] rd;
      logic [1:0]  e_aok;
      logic [1:0]  e_dok;
      logic        e_mreq;
      logic        e_busy;
   } vec_t;
   vec_t tv[$];

   task automatic add(input logic [1:0] req, input logic aok, input logic dok,
                      input logic [31:0] rd, input logic [1:0] e_aok,
                      input logic [1:0] e_dok, input logic e_mreq, input logic e_busy);
      vec_t v;
      v.req = req; v.wr = 2'b00; v.aok = aok; v.dok = dok; v.rd = rd;
      v.e_aok = e_aok; v.e_dok = e_dok; v.e_mreq = e_mreq; v.e_busy = e_busy;
      tv.push_back(v);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      ch_req = '0; mem_addr_ok = 1'b0; mem_data_ok = 1'b0;
      cyc(); cyc();
      rst = 1'b0;
   endtask

   task automatic drain();
      ch_req = '0; mem_addr_ok = 1'b1; mem_data_ok = 1'b1;
      repeat (6) cyc();
      mem_addr_ok = 1'b0; mem_data_ok = 1'b0;
      @(negedge clk);
      chk("drain_busy", busy, 0);
      cyc();
   endtask

   // Transaction-level reference: optional held request, queue of issued IDs.
   bit          m_hv;
   int          m_hid, m_pend, m_last;
   logic        m_hwr;
   logic [31:0] m_haddr, m_hwd;
   logic [3:0]  m_hws;
   int          m_sent[$];

   initial begin
      logic [NCH-1:0] rq;
      ch_req = '0; ch_wr = '0; ch_wstrb = '0; ch_addr = '0; ch_wdata = '0;
      mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = '0;

      // reset state
      @(negedge clk);
      chk("rst_mem_req", mem_req, 0);
      chk("rst_mem_wr", mem_wr, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_mem_wstrb", mem_wstrb, 0);
      chk("rst_busy", busy, 0);
      chk("rst_addr_ok", ch_addr_ok, 0);
      chk("rst_data_ok", ch_data_ok, 0);
      cyc();
      rst = 1'b0;

      // vector table: single read, then both channels until credit runs out
      add(2'b01, 1, 0, 32'h0,        2'b01, 2'b00, 0, 0);
      add(2'b00, 1, 0, 32'h0,        2'b00, 2'b00, 1, 1);
      add(2'b00, 0, 1, 32'h3C080001, 2'b00, 2'b01, 0, 1);
      add(2'b00, 0, 0, 32'h0,        2'b00, 2'b00, 0, 0);
      add(2'b11, 1, 0, 32'h0,        2'b10, 2'b00, 0, 0);
      add(2'b11, 1, 0, 32'h0,        2'b01, 2'b00, 1, 1);
      add(2'b11, 1, 0, 32'h0,        2'b10, 2'b00, 1, 1);
      add(2'b11, 1, 0, 32'h0,        2'b01, 2'b00, 1, 1);
      add(2'b11, 1, 0, 32'h0,        2'b00, 2'b00, 1, 1);
      add(2'b11, 1, 0, 32'h0,        2'b00, 2'b00, 0, 1);
      add(2'b11, 0, 1, 32'h11111111, 2'b00, 2'b10, 0, 1);
      add(2'b11, 0, 0, 32'h0,        2'b10, 2'b00, 0, 1);
      add(2'b00, 1, 1, 32'h22222222, 2'b00, 2'b01, 1, 1);
      add(2'b00, 0, 1, 32'h33333333, 2'b00, 2'b10, 0, 1);
      add(2'b00, 0, 1, 32'h44444444, 2'b00, 2'b01, 0, 1);
      add(2'b00, 0, 1, 32'h55555555, 2'b00, 2'b10, 0, 1);
      add(2'b00, 0, 1, 32'h66666666, 2'b00, 2'b00, 0, 0);
      add(2'b00, 0, 0, 32'h0,        2'b00, 2'b00, 0, 0);
      ch_addr[0] = 32'hBFC00000; ch_addr[1] = 32'h80000010;
      foreach (tv[i]) begin
         ch_req = tv[i].req; ch_wr = tv[i].wr;
         mem_addr_ok = tv[i].aok; mem_data_ok = tv[i].dok; mem_rdata = tv[i].rd;
         @(negedge clk);
         chk($sformatf("tv%0d_addr_ok", i), ch_addr_ok, tv[i].e_aok);
         chk($sformatf("tv%0d_data_ok", i), ch_data_ok, tv[i].e_dok);
         chk($sformatf("tv%0d_mem_req", i), mem_req, tv[i].e_mreq);
         chk($sformatf("tv%0d_busy", i), busy, tv[i].e_busy);
         if (tv[i].dok) chk($sformatf("tv%0d_rdata", i), ch_rdata, tv[i].rd);
         if (tv[i].e_mreq && i == 1) chk("tv1_mem_addr", mem_addr, 32'hBFC00000);
         cyc();
      end

      // round-robin alternation right after reset, channel 0 first
      do_reset();
      ch_req = 2'b11; mem_addr_ok = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk($sformatf("rr%0d_grant", i), ch_addr_ok, (i % 2 == 0) ? 2'b01 : 2'b10);
         cyc();
      end
      drain();

      // ch1 write then ch0 read; responses route ch1 then ch0
      ch_req = 2'b10; ch_wr = 2'b10; ch_wstrb[1] = 4'h3; ch_wdata[1] = 32'hCAFEF00D;
      mem_addr_ok = 1'b0;
      @(negedge clk); chk("mix_gnt1", ch_addr_ok, 2'b10);
      cyc();
      ch_req = 2'b01; ch_wr = 2'b00; mem_addr_ok = 1'b1;
      @(negedge clk);
      chk("mix_gnt0", ch_addr_ok, 2'b01);
      chk("mix_mem_wr", mem_wr, 1);
      chk("mix_wstrb", mem_wstrb, 4'h3);
      chk("mix_addr", mem_addr, 32'h80000010);
      chk("mix_wdata", mem_wdata, 32'hCAFEF00D);
      cyc();
      ch_req = 2'b00; mem_data_ok = 1'b1;
      @(negedge clk);
      chk("mix_dok1", ch_data_ok, 2'b10);
      chk("mix_rd_addr", mem_addr, 32'hBFC00000);
      chk("mix_rd_wr", mem_wr, 0);
      cyc();
      @(negedge clk); chk("mix_dok0", ch_data_ok, 2'b01);
      cyc();
      drain();

      // memory withholds addr_ok: request held stable, nothing new accepted
      ch_req = 2'b01; mem_addr_ok = 1'b0;
      @(negedge clk); chk("hold_gnt", ch_addr_ok, 2'b01);
      cyc();
      ch_addr[0] = 32'h00001000;
      for (int i = 0; i < 3; i++) begin
         mem_data_ok = (i == 1);
         @(negedge clk);
         chk($sformatf("hold%0d_addr_ok", i), ch_addr_ok, 2'b00);
         chk($sformatf("hold%0d_mem_req", i), mem_req, 1);
         chk($sformatf("hold%0d_mem_addr", i), mem_addr, 32'hBFC00000);
         chk($sformatf("hold%0d_data_ok", i), ch_data_ok, 2'b00);
         cyc();
      end
      mem_data_ok = 1'b0; mem_addr_ok = 1'b1;
      @(negedge clk); chk("hold_release_gnt", ch_addr_ok, 2'b01);
      cyc();
      ch_req = 2'b00;
      @(negedge clk); chk("hold_next_addr", mem_addr, 32'h00001000);
      cyc();
      drain();

      // reset with two outstanding, then a stray response
      ch_req = 2'b01; mem_addr_ok = 1'b1;
      cyc(); cyc();
      ch_req = 2'b00; cyc();
      ch_req = 2'b01; rst = 1'b1;
      #1;
      chk("mid_rst_mem_req", mem_req, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_addr_ok", ch_addr_ok, 0);
      chk("mid_rst_mem_addr", mem_addr, 0);
      cyc();
      rst = 1'b0; ch_req = 2'b00; mem_addr_ok = 1'b0; mem_data_ok = 1'b1;
      @(negedge clk);
      chk("stray_data_ok", ch_data_ok, 0);
      chk("stray_busy", busy, 0);
      cyc();
      mem_data_ok = 1'b0;
      cyc();

      // randomized traffic against the reference model
      do_reset();
      m_hv = 0; m_pend = 0; m_last = NCH - 1; m_sent.delete();
      m_hwr = 0; m_haddr = '0; m_hwd = '0; m_hws = '0; m_hid = 0;
      rq = '0;
      for (int cy = 0; cy < 1500; cy++) begin
         int g;
         bit cap, pop;
         logic [NCH-1:0] e_aok, e_dok;
         for (int c = 0; c < NCH; c++) begin
            if (!rq[c] && $urandom_range(0, 2) == 0) begin
               rq[c] = 1'b1;
               ch_wr[c] = 1'($urandom_range(0, 1));
               ch_addr[c] = $urandom;
               ch_wdata[c] = $urandom;
               ch_wstrb[c] = 4'($urandom_range(0, 15));
            end
         end
         ch_req = rq;
         mem_addr_ok = ($urandom_range(0, 3) != 0);
         mem_data_ok = ($urandom_range(0, 2) == 0);
         mem_rdata = $urandom;
         @(negedge clk);
         g = -1;
         for (int k = 1; k <= NCH; k++)
            if (g < 0 && ch_req[(m_last + k) % NCH]) g = (m_last + k) % NCH;
         cap = (g >= 0) && (!m_hv || mem_addr_ok) && (m_pend < DEPTH);
         pop = mem_data_ok && (m_sent.size() > 0);
         e_aok = '0; e_dok = '0;
         if (cap) e_aok[g] = 1'b1;
         if (pop) e_dok[m_sent[0]] = 1'b1;
         chk("rnd_addr_ok", ch_addr_ok, e_aok);
         chk("rnd_data_ok", ch_data_ok, e_dok);
         chk("rnd_mem_req", mem_req, m_hv);
         chk("rnd_busy", busy, m_pend != 0);
         if (pop) chk("rnd_rdata", ch_rdata, mem_rdata);
         if (m_hv) begin
            chk("rnd_mem_addr", mem_addr, m_haddr);
            chk("rnd_mem_wr", mem_wr, m_hwr);
            chk("rnd_mem_wdata", mem_wdata, m_hwd);
            chk("rnd_mem_wstrb", mem_wstrb, m_hws);
         end
         if (pop) void'(m_sent.pop_front());
         if (m_hv && mem_addr_ok) begin
            m_sent.push_back(m_hid);
            m_hv = 0;
         end
         if (cap) begin
            m_hv = 1; m_hid = g; m_last = g;
            m_hwr = ch_wr[g]; m_haddr = ch_addr[g]; m_hwd = ch_wdata[g]; m_hws = ch_wstrb[g];
            m_pend++;
         end
         if (pop) m_pend--;
         cyc();
         if (cap) rq[g] = 1'b0;
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
